// File: rtl/wb_stage.sv
// Write-back stage: one-entry commit register between the memory stage and the
// register-file write port. Optional retired-instruction counter under WB_RETIRE_CNT_EN.
module wb_stage #(
    parameter int BITSIZE = 32
) (
    input  logic               clk,
    input  logic               rstn_i,
    input  logic               valid_i,
    output logic               ack_o,
    input  logic [BITSIZE-1:0] instr_i,
    input  logic [BITSIZE-1:0] data_i,
    input  logic               rf_ready_i,
    output logic               rf_we_o,
    output logic [4:0]         rf_addr_o,
    output logic [BITSIZE-1:0] rf_data_o,
    output logic               fwd_valid_o,
    output logic [4:0]         fwd_rd_o,
    output logic [BITSIZE-1:0] fwd_data_o,
    output logic [63:0]        retired_o
);

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_FENCE  = 7'b0001111,
        OP_SYSTEM = 7'b1110011
    } opcode_e;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_f3_e;

    typedef struct packed {
        logic               valid;
        logic               we;
        logic [4:0]         rd;
        logic [BITSIZE-1:0] data;
    } wb_entry_t;

    wb_entry_t          wb_q;
    logic               commit;
    logic               accept;
    logic               we_dec;
    logic [BITSIZE-1:0] ext_data;
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [4:0]         rd_in;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign rd_in  = instr_i[11:7];

    // Immediate and source-register fields play no part in write-back.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr_i[BITSIZE-1:15];

    // Gating with rstn_i keeps ack_o low while the register is held in reset.
    assign commit = wb_q.valid & rf_ready_i;
    assign accept = rstn_i & valid_i & (~wb_q.valid | commit);
    assign ack_o  = accept;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        we_dec = 1'b0;
        case (opcode_e'(opcode))
            OP_LOAD, OP_IMM, OP_REG, OP_LUI,
            OP_AUIPC, OP_JAL, OP_JALR:          we_dec = 1'b1;
            OP_STORE, OP_BRANCH, OP_FENCE,
            OP_SYSTEM:                          we_dec = 1'b0;
            default:                            we_dec = 1'b0;
        endcase
        if (rd_in == 5'd0) begin
            we_dec = 1'b0;
        end
    end

    // Loads arrive right-aligned; only the sub-word forms need extension.
    always_comb begin
        ext_data = data_i;
        if (opcode == OP_LOAD) begin
            case (load_f3_e'(funct3))
                F3_LB:   ext_data = {{(BITSIZE-8){data_i[7]}}, data_i[7:0]};
                F3_LH:   ext_data = {{(BITSIZE-16){data_i[15]}}, data_i[15:0]};
                F3_LW:   ext_data = data_i;
                F3_LBU:  ext_data = {{(BITSIZE-8){1'b0}}, data_i[7:0]};
                F3_LHU:  ext_data = {{(BITSIZE-16){1'b0}}, data_i[15:0]};
                default: ext_data = data_i;
            endcase
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            wb_q <= '0;
        end else if (accept) begin
            wb_q <= '{valid: 1'b1, we: we_dec, rd: rd_in, data: ext_data};
        end else if (commit) begin
            wb_q.valid <= 1'b0;
        end
    end

    assign rf_we_o     = wb_q.valid & wb_q.we;
    assign rf_addr_o   = wb_q.rd;
    assign rf_data_o   = wb_q.data;
    assign fwd_valid_o = rf_we_o;
    assign fwd_rd_o    = wb_q.rd;
    assign fwd_data_o  = wb_q.data;

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt_q;

    // Wraps naturally from all-ones to zero.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            retire_cnt_q <= '0;
        end else if (commit) begin
            retire_cnt_q <= retire_cnt_q + 64'd1;
        end
    end

    assign retired_o = retire_cnt_q;
`else
    assign retired_o = 64'h0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus pushes expected register writes,
// a negedge monitor pops and compares on every committing write.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic        valid_i;
    logic        ack_o;
    logic [31:0] instr_i;
    logic [31:0] data_i;
    logic        rf_ready_i;
    logic        rf_we_o;
    logic [4:0]  rf_addr_o;
    logic [31:0] rf_data_o;
    logic        fwd_valid_o;
    logic [4:0]  fwd_rd_o;
    logic [31:0] fwd_data_o;
    logic [63:0] retired_o;

    always #5 clk = ~clk;

    wb_stage #(.BITSIZE(32)) dut (
        .clk         (clk),
        .rstn_i      (rstn_i),
        .valid_i     (valid_i),
        .ack_o       (ack_o),
        .instr_i     (instr_i),
        .data_i      (data_i),
        .rf_ready_i  (rf_ready_i),
        .rf_we_o     (rf_we_o),
        .rf_addr_o   (rf_addr_o),
        .rf_data_o   (rf_data_o),
        .fwd_valid_o (fwd_valid_o),
        .fwd_rd_o    (fwd_rd_o),
        .fwd_data_o  (fwd_data_o),
        .retired_o   (retired_o)
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  total = 0;
    int  bad   = 0;
    int  waited;
    logic [63:0] ret_snap;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd);
        return {17'h0, f3, rd, op};
    endfunction

    // Monitor: every write that lands must match the oldest expectation.
    always @(negedge clk) begin
        if (rstn_i && rf_we_o && rf_ready_i) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got rd=%0d data=%0h want none", rf_addr_o, rf_data_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 64'(rf_addr_o), 64'(mon_e.rd));
                check("wr_data", 64'(rf_data_o), 64'(mon_e.data));
                check("wr_fwd", 64'({fwd_valid_o, fwd_rd_o, fwd_data_o}), 64'({1'b1, mon_e.rd, mon_e.data}));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic [31:0] instr, input logic [31:0] data,
                        input logic exp_we, input logic [31:0] exp_data, output int w);
        valid_i = 1'b1;
        instr_i = instr;
        data_i  = data;
        w       = 0;
        @(negedge clk);
        while (!ack_o && w < 20) begin
            w++;
            @(negedge clk);
        end
        if (!ack_o) begin
            total++;
            bad++;
            $display("FAIL ack_timeout: got ack=0 want ack=1 within 20 cycles");
        end else if (exp_we) begin
            exp_q.push_back('{rd: instr[11:7], data: exp_data});
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"}, 64'(ack_o), 64'd0);
        check({tag, "_we"}, 64'(rf_we_o), 64'd0);
        check({tag, "_addr_data"}, 64'({rf_addr_o, rf_data_o}), 64'd0);
        check({tag, "_fwd"}, 64'({fwd_valid_o, fwd_rd_o, fwd_data_o}), 64'd0);
        check({tag, "_retired"}, retired_o, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200us");
        $fatal(1);
    end

    // Directed tables: {instr, data, expected we, expected data}
    logic [31:0] ld_instr [7];
    logic [31:0] ld_data  [7];
    logic [31:0] ld_exp   [7];
    logic [31:0] nw_instr [6];

    initial begin
        ld_instr[0] = mk(7'b0000011, 3'b000, 5'd3); ld_data[0] = 32'h0000_0080; ld_exp[0] = 32'hFFFF_FF80;
        ld_instr[1] = mk(7'b0000011, 3'b100, 5'd3); ld_data[1] = 32'h0000_0080; ld_exp[1] = 32'h0000_0080;
        ld_instr[2] = mk(7'b0000011, 3'b001, 5'd3); ld_data[2] = 32'h0000_8001; ld_exp[2] = 32'hFFFF_8001;
        ld_instr[3] = mk(7'b0000011, 3'b101, 5'd3); ld_data[3] = 32'h0000_8001; ld_exp[3] = 32'h0000_8001;
        ld_instr[4] = mk(7'b0000011, 3'b010, 5'd4); ld_data[4] = 32'h8000_0080; ld_exp[4] = 32'h8000_0080;
        ld_instr[5] = mk(7'b0000011, 3'b000, 5'd6); ld_data[5] = 32'h1234_567F; ld_exp[5] = 32'h0000_007F;
        ld_instr[6] = mk(7'b0000011, 3'b001, 5'd6); ld_data[6] = 32'hABCD_7FFF; ld_exp[6] = 32'h0000_7FFF;
        nw_instr[0] = mk(7'b0100011, 3'b010, 5'd8);   // SW
        nw_instr[1] = mk(7'b1100011, 3'b000, 5'd12);  // BEQ
        nw_instr[2] = mk(7'b0010011, 3'b000, 5'd0);   // ADDI x0
        nw_instr[3] = mk(7'b1111111, 3'b000, 5'd4);   // undefined
        nw_instr[4] = mk(7'b0001111, 3'b000, 5'd5);   // FENCE
        nw_instr[5] = mk(7'b1110011, 3'b000, 5'd6);   // SYSTEM

        rstn_i     = 1'b0;
        valid_i    = 1'b0;
        rf_ready_i = 1'b1;
        instr_i    = '0;
        data_i     = '0;

        @(negedge clk);
        check_reset_outputs("por");
        next_cycle();
        rstn_i = 1'b1;
        next_cycle();

        // ADDI x5: one-cycle latency to the write port.
        send(mk(7'b0010011, 3'b000, 5'd5), 32'h0000_1234, 1'b1, 32'h0000_1234, waited);
        check("addi_wait", 64'(waited), 64'd0);
        @(negedge clk);
        check("addi_we", 64'(rf_we_o), 64'd1);
        check("addi_addr", 64'(rf_addr_o), 64'd5);
        check("addi_data", 64'(rf_data_o), 64'h1234);
        check("addi_fwd_valid", 64'(fwd_valid_o), 64'd1);
        next_cycle();

        // Load extension, issued back-to-back.
        for (int i = 0; i < 7; i++) begin
            send(ld_instr[i], ld_data[i], 1'b1, ld_exp[i], waited);
            check("load_b2b_wait", 64'(waited), 64'd0);
        end

        // Four back-to-back writers, then backpressure on the last one.
        send(mk(7'b0110011, 3'b000, 5'd31), 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, waited);
        check("b2b0_wait", 64'(waited), 64'd0);
        send(mk(7'b0110111, 3'b000, 5'd7), 32'hDEAD_0000, 1'b1, 32'hDEAD_0000, waited);
        check("b2b1_wait", 64'(waited), 64'd0);
        send(mk(7'b1101111, 3'b000, 5'd1), 32'h0000_0104, 1'b1, 32'h0000_0104, waited);
        check("b2b2_wait", 64'(waited), 64'd0);
        send(mk(7'b1100111, 3'b000, 5'd2), 32'h0000_0208, 1'b1, 32'h0000_0208, waited);
        check("b2b3_wait", 64'(waited), 64'd0);

        rf_ready_i = 1'b0;
        valid_i    = 1'b1;
        instr_i    = mk(7'b0010111, 3'b000, 5'd9);
        data_i     = 32'h0000_0055;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_ack", 64'(ack_o), 64'd0);
            check("bp_hold", 64'({rf_we_o, rf_addr_o, rf_data_o}), 64'({1'b1, 5'd2, 32'h0000_0208}));
            check("bp_fwd", 64'(fwd_valid_o), 64'd1);
            next_cycle();
        end
        rf_ready_i = 1'b1;
        send(mk(7'b0010111, 3'b000, 5'd9), 32'h0000_0055, 1'b1, 32'h0000_0055, waited);
        check("bp_release_wait", 64'(waited), 64'd0);
        next_cycle();

        // Non-writing instructions still occupy the register and retire.
        ret_snap = retired_o;
        for (int i = 0; i < 6; i++) begin
            send(nw_instr[i], 32'h0000_0099, 1'b0, 32'h0, waited);
            @(negedge clk);
            check("nowrite_we", 64'(rf_we_o), 64'd0);
            check("nowrite_fwd", 64'(fwd_valid_o), 64'd0);
            next_cycle();
            if (i == 2) begin
`ifdef WB_RETIRE_CNT_EN
                check("retire_plus3", retired_o - ret_snap, 64'd3);
`else
                check("retire_tied0", retired_o, 64'd0);
`endif
            end
        end

        // Reset mid-stream with a write pending under backpressure.
        send(mk(7'b0010011, 3'b000, 5'd10), 32'h0000_AAAA, 1'b1, 32'h0000_AAAA, waited);
        rf_ready_i = 1'b0;
        valid_i    = 1'b1;
        instr_i    = mk(7'b0010011, 3'b000, 5'd12);
        data_i     = 32'h0000_BBBB;
        @(negedge clk);
        check("pend_we", 64'(rf_we_o), 64'd1);
        #2;
        rstn_i = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("midrst");
        next_cycle();
        valid_i    = 1'b0;
        rstn_i     = 1'b1;
        rf_ready_i = 1'b1;
        next_cycle();
        send(mk(7'b0010011, 3'b000, 5'd11), 32'h0000_0077, 1'b1, 32'h0000_0077, waited);
        check("postrst_wait", 64'(waited), 64'd0);
        @(negedge clk);
        check("postrst_out", 64'({rf_we_o, rf_addr_o, rf_data_o}), 64'({1'b1, 5'd11, 32'h0000_0077}));
        next_cycle();

`ifdef WB_RETIRE_CNT_EN
        check("postrst_retired", retired_o, 64'd1);
        force dut.retire_cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.retire_cnt_q;
        send(mk(7'b0010011, 3'b000, 5'd13), 32'h0000_0001, 1'b1, 32'h0000_0001, waited);
        next_cycle();
        check("retire_wrap", retired_o, 64'd0);
`else
        check("retired_tied0_end", retired_o, 64'd0);
`endif

        next_cycle();
        next_cycle();
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
